// File: rtl/note_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_link_pkg
// Description : Constants and types shared by both ends of the two-wire note
//               link (note_serializer / note_deserializer), so the transmitter
//               and receiver agree on frame width, bit period and gap length.
// Revision    : 1.0 - initial release
// ============================================================================
package note_link_pkg;

  localparam int NOTE_COUNT      = 48;   // bits per frame
  localparam int NOTE_BIT_PERIOD = 128;  // clocks per serial bit
  localparam int NOTE_GAP_BITS   = 2;    // idle bit periods after the last bit
  localparam int FRAME_CNT_W     = 8;    // width of the completed-frame counter

  // Transmitter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } note_tx_state_e;

endpackage : note_link_pkg
`default_nettype wire

// File: rtl/note_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : note_bit_timer
// Description : Free-running 0..BIT_PERIOD-1 tick counter used to time one
//               serial bit. Also suitable as the receiver's sample strobe.
// Revision    : 1.0 - initial release
// Ports       : clk          in  system clock
//               rst_n        in  asynchronous active-low reset
//               i_clear      in  force the counter back to 0 (wins over run)
//               i_run        in  advance the counter this cycle
//               o_tick_last  out counter is at BIT_PERIOD-1 (last clock of bit)
// ============================================================================
module note_bit_timer
  import note_link_pkg::*;
#(
  parameter int BIT_PERIOD = NOTE_BIT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick_last
);

  localparam int             TICK_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [TICK_W-1:0] c_LAST_TICK = TICK_W'(BIT_PERIOD - 1);

  logic [TICK_W-1:0] r_tick;
  logic              w_last;

  assign w_last      = (r_tick == c_LAST_TICK);
  assign o_tick_last = w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
    end else if (i_clear) begin
      r_tick <= '0;
    end else if (i_run) begin
      // Wrap on the last tick so the next bit starts at 0 without a clear.
      r_tick <= w_last ? '0 : r_tick + TICK_W'(1);
    end
  end

endmodule : note_bit_timer
`default_nettype wire

// File: rtl/note_serializer.sv
`default_nettype none
// ============================================================================
// Module      : note_serializer
// Description : Transmit end of the two-wire note link. Snapshots a
//               NUM_NOTES-wide active-note vector and shifts it out LSB-first,
//               each bit held for BIT_PERIOD clocks, sync high during bit 0,
//               followed by GAP_BITS idle bit periods.
// Revision    : 1.0 - initial release
// Ports       : clk                 in  system clock
//               rst_n               in  asynchronous active-low reset
//               i_enable            in  permit new frames (sampled in IDLE)
//               i_active_in         in  next note vector
//               i_active_valid      in  vector valid (accepted with ready)
//               o_active_ready      out pending buffer empty
//               o_note_serial_sync  out frame marker, high during bit 0
//               o_note_serial_data  out current serial bit
//               o_busy              out frame in progress
//               o_frame_done        out 1-cycle pulse when returning to IDLE
//               o_frame_count       out frames completed (wraps)
// ============================================================================
module note_serializer
  import note_link_pkg::*;
#(
  parameter int NUM_NOTES  = NOTE_COUNT,
  parameter int BIT_PERIOD = NOTE_BIT_PERIOD,
  parameter int GAP_BITS   = NOTE_GAP_BITS,
  parameter int REPEAT     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enable,
  input  logic [NUM_NOTES-1:0]   i_active_in,
  input  logic                   i_active_valid,
  output logic                   o_active_ready,
  output logic                   o_note_serial_sync,
  output logic                   o_note_serial_data,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic [FRAME_CNT_W-1:0] o_frame_count
);

  localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(NUM_NOTES - 1);
  localparam logic [GAP_W-1:0] c_LAST_GAP  = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic             c_REPEAT_EN = (REPEAT != 0);

  note_tx_state_e         r_state;
  logic [NUM_NOTES-1:0]   r_pend;
  logic                   r_pend_valid;
  logic [NUM_NOTES-1:0]   r_last;
  logic                   r_loaded;      // a frame has been sent since reset
  logic [NUM_NOTES-1:0]   r_shift;
  logic [IDX_W-1:0]       r_bit_idx;
  logic [GAP_W-1:0]       r_gap_idx;
  logic                   r_sync;
  logic                   r_data;
  logic                   r_frame_done;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  logic                   w_tick_last;
  logic                   w_accept;
  logic                   w_start;
  logic [NUM_NOTES-1:0]   w_start_vec;
  logic [IDX_W-1:0]       w_next_idx;

  assign w_accept    = i_active_valid & ~r_pend_valid;
  assign w_start     = (r_state == ST_IDLE) & i_enable &
                       (r_pend_valid | (c_REPEAT_EN & r_loaded));
  assign w_start_vec = r_pend_valid ? r_pend : r_last;
  assign w_next_idx  = r_bit_idx + IDX_W'(1);

  note_bit_timer #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_bit_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start),
    .i_run       (r_state != ST_IDLE),
    .o_tick_last (w_tick_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pend        <= '0;
      r_pend_valid  <= 1'b0;
      r_last        <= '0;
      r_loaded      <= 1'b0;
      r_shift       <= '0;
      r_bit_idx     <= '0;
      r_gap_idx     <= '0;
      r_sync        <= 1'b0;
      r_data        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_done <= 1'b0;

      if (w_accept) begin
        r_pend       <= i_active_in;
        r_pend_valid <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_SHIFT;
            r_shift   <= w_start_vec;
            r_last    <= w_start_vec;
            r_loaded  <= 1'b1;
            // Only clear when actually consumed, so a same-cycle accept
            // during a repeat start is not lost.
            if (r_pend_valid) begin
              r_pend_valid <= 1'b0;
            end
            r_bit_idx <= '0;
            r_gap_idx <= '0;
            r_sync    <= 1'b1;
            r_data    <= w_start_vec[0];
          end
        end
        ST_SHIFT: begin
          if (w_tick_last) begin
            r_sync <= 1'b0;
            if (r_bit_idx == c_LAST_IDX) begin
              r_data <= 1'b0;
              if (GAP_BITS == 0) begin
                r_state       <= ST_IDLE;
                r_frame_done  <= 1'b1;
                r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
              end else begin
                r_state <= ST_GAP;
              end
            end else begin
              r_bit_idx <= w_next_idx;
              r_data    <= r_shift[w_next_idx];
            end
          end
        end
        ST_GAP: begin
          if (w_tick_last) begin
            if (r_gap_idx == c_LAST_GAP) begin
              r_state       <= ST_IDLE;
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
            end else begin
              r_gap_idx <= r_gap_idx + GAP_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_active_ready     = ~r_pend_valid;
  assign o_note_serial_sync = r_sync;
  assign o_note_serial_data = r_data;
  assign o_busy             = (r_state != ST_IDLE);
  assign o_frame_done       = r_frame_done;
  assign o_frame_count      = r_frame_count;

endmodule : note_serializer
`default_nettype wire
